// File: rtl/hex_scroll_msg_pkg.sv
`default_nettype none
// ============================================================================
// hex_msg_pkg : glyph codes, segment patterns and message ROM for hex_scroll_msg
// Revision    : 1.0
// ============================================================================
package hex_msg_pkg;

    localparam int MSG_LEN = 8;

    localparam logic [3:0] G_BLANK = 4'd0;
    localparam logic [3:0] G_H     = 4'd1;
    localparam logic [3:0] G_E     = 4'd2;
    localparam logic [3:0] G_L     = 4'd3;
    localparam logic [3:0] G_P     = 4'd4;
    localparam logic [3:0] G_O     = 4'd5;
    localparam logic [3:0] G_A     = 4'd6;
    localparam logic [3:0] G_DASH  = 4'd7;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Rows are packed with character 0 in the least significant nibble.
    function automatic logic [3:0] msg_rom(input logic [1:0] sel, input logic [2:0] idx);
        logic [31:0] row;
        case (sel)
            2'd0:    row = {G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_P, G_L, G_E, G_H};
            2'd1:    row = {G_BLANK, G_BLANK, G_BLANK, G_O, G_L, G_L, G_E, G_H};
            2'd2:    row = {G_DASH, G_A, G_L, G_O, G_DASH, G_A, G_L, G_O};
            default: row = {G_BLANK, G_BLANK, G_DASH, G_P, G_L, G_E, G_H, G_DASH};
        endcase
        return row[{idx, 2'b00} +: 4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scroll_msg_if.sv
`default_nettype none
// ============================================================================
// hex_scroll_msg_if : board-side keys, switches and HEX digit bundle
// Revision          : 1.0
// ============================================================================
interface hex_scroll_msg_if;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX3;
    logic [6:0] HEX2;
    logic [6:0] HEX1;
    logic [6:0] HEX0;

    modport master (output KEY, output SW, input HEX3, input HEX2, input HEX1, input HEX0);
    modport slave  (input KEY, input SW, output HEX3, output HEX2, output HEX1, output HEX0);
endinterface
`default_nettype wire

// File: rtl/hex_scroll_msg_seg_glyph_dec.sv
`default_nettype none
// ============================================================================
// seg_glyph_dec : 4-bit glyph code to active-low 7-segment pattern
// Revision      : 1.0
// ============================================================================
module seg_glyph_dec
    import hex_msg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (code_i)
            G_H:     seg_o = SEG_H;
            G_E:     seg_o = SEG_E;
            G_L:     seg_o = SEG_L;
            G_P:     seg_o = SEG_P;
            G_O:     seg_o = SEG_O;
            G_A:     seg_o = SEG_A;
            G_DASH:  seg_o = SEG_DASH;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_msg.sv
`default_nettype none
// ============================================================================
// hex_scroll_msg : scrolls a ROM message right-to-left across HEX3..HEX0
// Revision       : 1.0
// ============================================================================
module hex_scroll_msg
    import hex_msg_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic              CLOCK_50,
    hex_scroll_msg_if.slave   bus
);

    localparam logic [25:0] TICK_DIV_C = 26'(TICK_DIV);

    logic [2:1]  key_s1_q, key_s2_q, key_s3_q;
    logic [9:0]  sw_s1_q, sw_s2_q;
    logic [1:0]  sel_prev_q;
    logic [25:0] cnt_q, cnt_d;
    logic [2:0]  pos_q, pos_d;
    state_e      state_q, state_d;
    logic [6:0]  hex_q [4];
    logic [6:0]  seg   [4];

    logic        en, paused, counting, tick, msg_change, pause_press, step_press;
    logic [1:0]  sel, speed;
    logic [25:0] div_w, term;
    logic [2:0]  pos_inc;
    logic        unused_bits;

    assign en          = sw_s2_q[0];
    assign sel         = sw_s2_q[2:1];
    assign speed       = sw_s2_q[9:8];
    assign unused_bits = ^{bus.KEY[3], sw_s2_q[7:3]};

    assign pause_press = key_s3_q[1] & ~key_s2_q[1];
    assign step_press  = key_s3_q[2] & ~key_s2_q[2];
    assign msg_change  = (sel != sel_prev_q);
    assign paused      = (state_q == ST_PAUSE);

    // The fastest setting can shift the divider to zero; clamp so it ticks every cycle.
    assign div_w    = TICK_DIV_C >> speed;
    assign term     = (div_w == 26'd0) ? 26'd0 : div_w - 26'd1;
    assign counting = en & ~paused;
    assign tick     = counting & (cnt_q >= term);
    assign pos_inc  = (pos_q == 3'(MSG_LEN - 1)) ? 3'd0 : pos_q + 3'd1;

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_BLANK;
        end else begin
            case (state_q)
                ST_BLANK: state_d = ST_RUN;
                ST_RUN:   if (pause_press) state_d = ST_PAUSE;
                ST_PAUSE: if (pause_press) state_d = ST_RUN;
                default:  state_d = ST_BLANK;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        pos_d = pos_q;
        if (!en || msg_change) begin
            cnt_d = 26'd0;
            pos_d = 3'd0;
        end else if (tick) begin
            cnt_d = 26'd0;
            pos_d = pos_inc;
        end else if (counting) begin
            cnt_d = cnt_q + 26'd1;
        end else if (step_press && paused) begin
            pos_d = pos_inc;
        end
    end

    // Decoding from the next position lets the digits update on the same edge as pos.
    for (genvar g = 0; g < 4; g++) begin : g_digit
        logic [2:0] idx;
        assign idx = pos_d + 3'(g);
        seg_glyph_dec u_dec (
            .code_i (msg_rom(sel, idx)),
            .seg_o  (seg[g])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (!bus.KEY[0]) begin
            key_s1_q   <= '0;
            key_s2_q   <= '0;
            key_s3_q   <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            sel_prev_q <= '0;
            cnt_q      <= '0;
            pos_q      <= '0;
            state_q    <= ST_BLANK;
            for (int i = 0; i < 4; i++) hex_q[i] <= SEG_BLANK;
        end else begin
            key_s1_q   <= bus.KEY[2:1];
            key_s2_q   <= key_s1_q;
            key_s3_q   <= key_s2_q;
            sw_s1_q    <= bus.SW;
            sw_s2_q    <= sw_s1_q;
            sel_prev_q <= sel;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            state_q    <= state_d;
            for (int i = 0; i < 4; i++) hex_q[i] <= en ? seg[i] : SEG_BLANK;
        end
    end

    assign bus.HEX3 = hex_q[0];
    assign bus.HEX2 = hex_q[1];
    assign bus.HEX1 = hex_q[2];
    assign bus.HEX0 = hex_q[3];

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_msg.sv
`default_nettype none
// ============================================================================
// tb_hex_scroll_msg : directed self-checking bench for hex_scroll_msg
// Revision          : 1.0
// ============================================================================
module tb_hex_scroll_msg;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    hex_scroll_msg_if bus ();

    hex_scroll_msg #(.TICK_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;

    function automatic logic [6:0] chr(input int m, input int i);
        string s;
        byte   c;
        case (m)
            0:       s = "HELP    ";
            1:       s = "HELLO   ";
            2:       s = "OLA-OLA-";
            default: s = "-HELP-  ";
        endcase
        c = s[i % 8];
        case (c)
            "H":     return 7'b0001001;
            "E":     return 7'b0000110;
            "L":     return 7'b1000111;
            "P":     return 7'b0001100;
            "O":     return 7'b1000000;
            "A":     return 7'b0001000;
            "-":     return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] win(input int m, input int p);
        return {chr(m, p), chr(m, p + 1), chr(m, p + 2), chr(m, p + 3)};
    endfunction

    function automatic logic [27:0] cur();
        return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    endfunction

    function automatic int find_pos(input int m);
        for (int p = 0; p < 8; p++)
            if (cur() === win(m, p)) return p;
        return -1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_win(input int m, input int p, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cur() === win(m, p)) begin
                ok = 1'b1;
                return;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        bus.KEY = 4'b1110;
        bus.SW  = 10'b0000000001;
        cyc(3);
        n_tests++;
        if (cur() !== ALL_BLANK) begin
            n_fail++; $display("FAIL reset_blank: got %h want %h", cur(), ALL_BLANK);
        end
        bus.KEY = 4'b1111;
        cyc(2);
        n_tests++;
        if (cur() !== ALL_BLANK) begin
            n_fail++; $display("FAIL sync_blank: got %h want %h", cur(), ALL_BLANK);
        end
        cyc(1);
        n_tests++;
        if (cur() !== win(0, 0)) begin
            n_fail++; $display("FAIL first_help: got %h want %h", cur(), win(0, 0));
        end
        cyc(3);
        n_tests++;
        if (cur() !== win(0, 1)) begin
            n_fail++; $display("FAIL first_tick: got %h want %h", cur(), win(0, 1));
        end
        cyc(12);
        n_tests++;
        if (cur() !== ALL_BLANK) begin
            n_fail++; $display("FAIL four_ticks_blank: got %h want %h", cur(), ALL_BLANK);
        end
        cyc(16);
        n_tests++;
        if (cur() !== win(0, 0)) begin
            n_fail++; $display("FAIL eight_ticks_wrap: got %h want %h", cur(), win(0, 0));
        end
    endtask

    task automatic test_speed();
        int p;
        for (int sp = 2; sp < 4; sp++) begin
            bus.SW = {2'(sp), 8'b00000001};
            cyc(4);
            p = find_pos(0);
            n_tests++;
            if (p < 0) begin
                n_fail++; $display("FAIL speed%0d_window: got %h want any HELP rotation", sp, cur());
                p = 0;
            end
            cyc(1);
            n_tests++;
            if (cur() !== win(0, p + 1)) begin
                n_fail++; $display("FAIL speed%0d_step: got %h want %h", sp, cur(), win(0, p + 1));
            end
            cyc(7);
            n_tests++;
            if (cur() !== win(0, p)) begin
                n_fail++; $display("FAIL speed%0d_wrap8: got %h want %h", sp, cur(), win(0, p));
            end
        end
        bus.SW = 10'b0000000001;
        cyc(4);
    endtask

    task automatic test_pause_step();
        bit ok;
        bit frozen;
        wait_win(0, 0, 40, ok);
        wait_win(0, 1, 8, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL reach_pos1: got %h want %h", cur(), win(0, 1));
        end
        // Press timed so it lands on the same cycle as the tick into pos 2.
        cyc(1);
        bus.KEY = 4'b1101;
        cyc(1);
        bus.KEY = 4'b1111;
        cyc(3);
        n_tests++;
        if (cur() !== win(0, 2)) begin
            n_fail++; $display("FAIL pause_pos2: got %h want %h", cur(), win(0, 2));
        end
        frozen = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (cur() !== win(0, 2)) frozen = 1'b0;
        end
        n_tests++;
        if (!frozen) begin
            n_fail++; $display("FAIL pause_hold: got %h want %h", cur(), win(0, 2));
        end
        bus.KEY = 4'b1011;
        cyc(1);
        bus.KEY = 4'b1111;
        cyc(5);
        n_tests++;
        if (cur() !== win(0, 3)) begin
            n_fail++; $display("FAIL step_once: got %h want %h", cur(), win(0, 3));
        end
        cyc(20);
        n_tests++;
        if (cur() !== win(0, 3)) begin
            n_fail++; $display("FAIL step_hold: got %h want %h", cur(), win(0, 3));
        end
        bus.KEY = 4'b1101;
        cyc(1);
        bus.KEY = 4'b1111;
        wait_win(0, 4, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL resume: got %h want %h", cur(), win(0, 4));
        end
    endtask

    task automatic test_msg_change();
        bit ok;
        wait_win(0, 4, 20, ok);
        wait_win(0, 5, 8, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL reach_pos5: got %h want %h", cur(), win(0, 5));
        end
        bus.SW = 10'b0000000011;
        cyc(3);
        n_tests++;
        if (cur() !== win(1, 0)) begin
            n_fail++; $display("FAIL msg_hell: got %h want %h", cur(), win(1, 0));
        end
        cyc(3);
        n_tests++;
        if (cur() !== win(1, 0)) begin
            n_fail++; $display("FAIL msg_presc_hold: got %h want %h", cur(), win(1, 0));
        end
        cyc(1);
        n_tests++;
        if (cur() !== win(1, 1)) begin
            n_fail++; $display("FAIL msg_presc_tick: got %h want %h", cur(), win(1, 1));
        end
    endtask

    task automatic test_enable();
        bus.KEY = 4'b1101;
        cyc(1);
        bus.KEY = 4'b1111;
        cyc(6);
        n_tests++;
        if (cur() !== win(1, 1)) begin
            n_fail++; $display("FAIL en_paused: got %h want %h", cur(), win(1, 1));
        end
        bus.SW = 10'b0000000010;
        cyc(3);
        n_tests++;
        if (cur() !== ALL_BLANK) begin
            n_fail++; $display("FAIL en_off_blank: got %h want %h", cur(), ALL_BLANK);
        end
        bus.SW = 10'b0000000011;
        cyc(3);
        n_tests++;
        if (cur() !== win(1, 0)) begin
            n_fail++; $display("FAIL en_on_pos0: got %h want %h", cur(), win(1, 0));
        end
        cyc(3);
        n_tests++;
        if (cur() !== win(1, 1)) begin
            n_fail++; $display("FAIL en_pause_cleared: got %h want %h", cur(), win(1, 1));
        end
    endtask

    task automatic test_reset_midscroll();
        bit ok;
        bus.SW = 10'b0000000001;
        wait_win(0, 5, 40, ok);
        wait_win(0, 6, 8, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL reach_pos6: got %h want %h", cur(), win(0, 6));
        end
        bus.KEY = 4'b1110;
        cyc(1);
        n_tests++;
        if (cur() !== ALL_BLANK) begin
            n_fail++; $display("FAIL mid_reset_blank: got %h want %h", cur(), ALL_BLANK);
        end
        bus.KEY = 4'b1111;
        cyc(3);
        n_tests++;
        if (cur() !== win(0, 0)) begin
            n_fail++; $display("FAIL mid_reset_help: got %h want %h", cur(), win(0, 0));
        end
        cyc(3);
        n_tests++;
        if (cur() !== win(0, 1)) begin
            n_fail++; $display("FAIL mid_reset_tick: got %h want %h", cur(), win(0, 1));
        end
    endtask

    initial begin
        bus.KEY = 4'b1110;
        bus.SW  = 10'b0000000001;
        cyc(1);
        test_reset();
        test_speed();
        test_pause_step();
        test_msg_change();
        test_enable();
        test_reset_midscroll();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
